mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares one single-port synchronous data SRAM between the core data port and a host port (debug/loader). It sits between the core's `d_*` bus and the SRAM macro, grants one access per arbitration cycle with round-robin priority, inserts the one-cycle SRAM read latency into the req/ready handshake, and flags accesses outside the populated address range.

## Interface
- `AW`, 12: SRAM word-address width; memory is 2^AW 32-bit words.
- `clk`  in  1  clock; all state on rising edge.
- `rstb`  in  1  reset, asynchronous, active-low.
- `c_addr`  in  32  core byte address; bits [1:0] ignored.
- `c_rd_req` / `c_wr_req`  in  1  core read / write request, held until the matching ready.
- `c_wr_be`  in  4  core write byte enables.
- `c_wr_data`  in  32  core write data, already lane-aligned.
- `c_rd_ready` / `c_wr_ready`  out  1  core read / write completion strobe, one cycle.
- `c_rd_data`  out  32  core read data, valid only while `c_rd_ready`.
- `h_addr`, `h_rd_req`, `h_wr_req`, `h_wr_be`, `h_wr_data`, `h_rd_ready`, `h_wr_ready`, `h_rd_data`: host port, same widths and rules as the core port.
- `m_en`  out  1  SRAM access enable.
- `m_we`  out  1  SRAM write enable; qualified by `m_en`.
- `m_be`  out  4  SRAM byte write enables.
- `m_addr`  out  AW  SRAM word address.
- `m_wdata`  out  32  SRAM write data.
- `m_rdata`  in  32  SRAM read data, valid the cycle after a read enable.
- `err_clr`  in  1  clears `addr_err`.
- `addr_err`  out  1  sticky flag: an out-of-range access occurred.
- `last_grant`  out  1  0 = core, 1 = host; port that won the most recent grant.

## Operation
- FSM states: IDLE, RD_C (core read in flight), RD_H (host read in flight).
- **Pending requests.** In IDLE, a port is pending if its `rd_req` or `wr_req` is high.
  - If a port raises both, its write is serviced first. The read stays pending.
- **Arbitration.**
  - With one pending port, that port is granted.
  - With both pending, the port with priority is granted. The priority register `prio` resets to core.
  - After every grant, `prio` points to the non-granted port, so continuous contention alternates core, host, core, and so on.
  - `last_grant` is updated on every grant.
- **Range check.** An address is out of range when `addr[31:AW+2] != 0`. `m_addr = addr[AW+1:2]`.
- **Granted in-range write.**
  - Same cycle: `m_en=1`, `m_we=1`, `m_be`/`m_wdata` from the winner, winner's `wr_ready=1`.
  - FSM stays in IDLE.
- **Granted in-range read.**
  - Same cycle: `m_en=1`, `m_we=0`.
  - Next state RD_C or RD_H.
- **RD_x state.**
  - The port's `rd_ready=1` and `rd_data=m_rdata`. Next state IDLE.
  - No grant is issued in RD_x, and the other port keeps waiting.
- **Granted out-of-range access.**
  - `m_en=0`.
  - `addr_err` sets on the next edge.
  - Writes: `wr_ready=1` in the same cycle; data is dropped.
  - Reads: still go through RD_x; `rd_data=0` in the ready cycle. A registered flag records the error.
- **`addr_err` edge cases.**
  - If `err_clr` and a new error occur in the same cycle, set wins.
  - `err_clr` with no new error clears the flag on the next edge.
- **Port outputs outside their ready cycle.**
  - `rd_data` = 0.
  - `rd_ready` = `wr_ready` = 0.
- Dropping a request before its ready is a protocol violation; behaviour is undefined. Addresses and data must stay stable while the request is pending.

## Timing
- Reset values:
  - FSM = IDLE, `prio` = core, `last_grant` = 0, `addr_err` = 0.
  - All ready outputs = 0, `m_en` = `m_we` = 0, `m_be` = 0, `m_addr` = 0, `m_wdata` = 0, both `rd_data` = 0.
- Write latency: 0 cycles. `wr_ready` is combinational in the grant cycle, which matches the core's combinational store request and PC stall.
- Read latency:
  - `rd_ready` is asserted exactly 1 cycle after the grant cycle.
  - The requester samples `rd_data` on the edge ending its ready cycle, then drops `rd_req`.
- Throughput: a write every cycle; a read every 2 cycles. A write can be granted in the IDLE cycle immediately following RD_x.
- Simultaneous core read and host write, `prio` = core:
  - Cycle 0: core read granted.
  - Cycle 1: core `rd_ready`.
  - Cycle 2: host write granted.
- Reset mid-read: the FSM returns to IDLE asynchronously, the pending `rd_ready` is never issued, and the requester reissues after reset.

## Test plan
- **Core write then read.** Core writes 0xDEADBEEF to 0x10 with `be`=F, then reads 0x10 → `c_wr_ready` in cycle 0, `m_addr`=4; `c_rd_ready` one cycle after the read grant with `c_rd_data`=0xDEADBEEF.
- **Byte-enable masking.** Core writes 0x0000AB00 with `be`=2 over 0x11223344 at 0x20 → a later read returns 0x1122AB44.
- **Continuous contention.** Core and host both issue writes every cycle for 6 cycles → grants go C,H,C,H,C,H; `last_grant` toggles each cycle.
- **Read vs. write contention.** Host read of 0x40 and core write of 0x40 (value 0x5) both pending with `prio`=host → host reads the old value; core's write is granted in the cycle after the host's `rd_ready`.
- **Out-of-range access.** With AW=12, core reads 0x4000 → `m_en`=0, `c_rd_ready` after 1 cycle with data 0, `addr_err`=1; `err_clr` pulse clears it; an out-of-range write with a simultaneous `err_clr` leaves `addr_err`=1.
- **Reset mid-read.** Assert `rstb`=0 in the cycle after a read grant → `c_rd_ready` never pulses; all outputs at reset values; the first post-reset request is granted to core.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the SRAM arbiter: one instance per port (core, host).
// Requests are held until the matching one-cycle ready strobe.
interface mem_arbiter_if;
    logic [31:0] addr;
    logic        rd_req;
    logic        wr_req;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        rd_ready;
    logic        wr_ready;
    logic [31:0] rd_data;

    modport master (
        output addr, rd_req, wr_req, wr_be, wr_data,
        input  rd_ready, wr_ready, rd_data
    );

    modport slave (
        input  addr, rd_req, wr_req, wr_be, wr_data,
        output rd_ready, wr_ready, rd_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous SRAM between the core
// and host ports; folds the one-cycle read latency into the req/ready handshake.
module mem_arbiter #(
    parameter int unsigned AW = 12
) (
    input  logic          clk,
    input  logic          rstb,
    mem_arbiter_if.slave  core,
    mem_arbiter_if.slave  host,
    output logic          m_en,
    output logic          m_we,
    output logic [3:0]    m_be,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_wdata,
    input  logic [31:0]   m_rdata,
    input  logic          err_clr,
    output logic          addr_err,
    output logic          last_grant
);

    typedef enum logic [1:0] {IDLE, RD_C, RD_H} state_t;

    state_t      state;
    logic        prio;
    logic        rd_err;

    logic        core_pend;
    logic        host_pend;
    logic        grant;
    logic        win;
    logic [31:0] w_addr;
    logic        w_wr;
    logic [3:0]  w_be;
    logic [31:0] w_data;
    logic        oor;
    logic        unused_addr_lsb;

    // Winner selection and same-cycle SRAM / write-ready drive; gated by rstb so
    // every output sits at its reset value while reset is asserted.
    always_comb begin
        core_pend = core.rd_req | core.wr_req;
        host_pend = host.rd_req | host.wr_req;
        grant     = rstb && (state == IDLE) && (core_pend || host_pend);
        win       = host_pend && (!core_pend || prio);
        w_addr    = win ? host.addr    : core.addr;
        w_wr      = win ? host.wr_req  : core.wr_req;
        w_be      = win ? host.wr_be   : core.wr_be;
        w_data    = win ? host.wr_data : core.wr_data;
        oor       = |w_addr[31:AW+2];

        m_en          = 1'b0;
        m_we          = 1'b0;
        m_be          = 4'h0;
        m_addr        = '0;
        m_wdata       = 32'h0;
        core.wr_ready = 1'b0;
        host.wr_ready = 1'b0;
        core.rd_ready = 1'b0;
        host.rd_ready = 1'b0;
        core.rd_data  = 32'h0;
        host.rd_data  = 32'h0;

        if (grant) begin
            if (!oor) begin
                m_en   = 1'b1;
                m_we   = w_wr;
                m_addr = w_addr[AW+1:2];
                if (w_wr) begin
                    m_be    = w_be;
                    m_wdata = w_data;
                end
            end
            if (w_wr) begin
                if (win) host.wr_ready = 1'b1;
                else     core.wr_ready = 1'b1;
            end
        end

        // Read completion: out-of-range reads return zero instead of stale SRAM data
        if (state == RD_C) begin
            core.rd_ready = 1'b1;
            core.rd_data  = rd_err ? 32'h0 : m_rdata;
        end
        if (state == RD_H) begin
            host.rd_ready = 1'b1;
            host.rd_data  = rd_err ? 32'h0 : m_rdata;
        end
    end

    assign unused_addr_lsb = ^{core.addr[1:0], host.addr[1:0]};

    // FSM, round-robin pointer and sticky error flag
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state      <= IDLE;
            prio       <= 1'b0;
            last_grant <= 1'b0;
            addr_err   <= 1'b0;
            rd_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        prio       <= ~win;
                        last_grant <= win;
                        if (!w_wr) begin
                            state  <= win ? RD_H : RD_C;
                            rd_err <= oor;
                        end
                    end
                end
                RD_C, RD_H: state <= IDLE;
                default:    state <= IDLE;
            endcase

            if (grant && oor) addr_err <= 1'b1;
            else if (err_clr) addr_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed multi-cycle
// sequences, and a randomized phase checked against a transaction-level model.
module tb_mem_arbiter;
    localparam int unsigned AW = 12;

    logic          clk = 1'b0;
    logic          rstb;
    logic          err_clr;
    logic          m_en, m_we;
    logic [3:0]    m_be;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;
    logic [31:0]   m_rdata = 32'h0;
    logic          addr_err, last_grant;

    always #5 clk = ~clk;

    mem_arbiter_if core_if ();
    mem_arbiter_if host_if ();

    mem_arbiter #(.AW(AW)) dut (
        .clk(clk), .rstb(rstb), .core(core_if), .host(host_if),
        .m_en(m_en), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .err_clr(err_clr),
        .addr_err(addr_err), .last_grant(last_grant)
    );

    // Behavioural single-port SRAM with one-cycle read latency
    logic [31:0] sram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) begin
                for (int b = 0; b < 4; b++)
                    if (m_be[b]) sram[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
            end else begin
                m_rdata <= sram[m_addr];
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        core_if.addr = 0; core_if.rd_req = 0; core_if.wr_req = 0; core_if.wr_be = 0; core_if.wr_data = 0;
        host_if.addr = 0; host_if.rd_req = 0; host_if.wr_req = 0; host_if.wr_be = 0; host_if.wr_data = 0;
        err_clr = 0;
    endtask

    task automatic do_reset();
        rstb = 1'b0;
        clear_inputs();
        tick();
        tick();
        rstb = 1'b1;
    endtask

    task automatic core_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        core_if.addr = a; core_if.wr_data = d; core_if.wr_be = be; core_if.wr_req = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        c_wr, h_wr;
        logic [31:0] c_addr, h_addr;
        logic        clr;
        logic        e_c_rdy, e_h_rdy, e_en;
        logic [11:0] e_maddr;
        logic        e_err, e_lg;
    } vec_t;

    vec_t vecs [8];

    // ---------------- random-phase state ----------------
    logic        p_rd [2], p_wr [2];
    logic [31:0] p_addr [2], p_wdata [2];
    logic [3:0]  p_be [2];
    int          p_age [2];
    logic [31:0] model [16];
    logic        oor_seen;

    logic        rrdy [2], wrdy [2];
    logic [31:0] rdat [2];
    assign rrdy[0] = core_if.rd_ready;  assign rrdy[1] = host_if.rd_ready;
    assign wrdy[0] = core_if.wr_ready;  assign wrdy[1] = host_if.wr_ready;
    assign rdat[0] = core_if.rd_data;   assign rdat[1] = host_if.rd_data;

    task automatic drive_ports();
        core_if.rd_req = p_rd[0]; core_if.wr_req = p_wr[0]; core_if.addr = p_addr[0];
        core_if.wr_be  = p_be[0]; core_if.wr_data = p_wdata[0];
        host_if.rd_req = p_rd[1]; host_if.wr_req = p_wr[1]; host_if.addr = p_addr[1];
        host_if.wr_be  = p_be[1]; host_if.wr_data = p_wdata[1];
    endtask

    function automatic logic in_range(input logic [31:0] a);
        return a < 32'(1 << (AW + 2));
    endfunction

    initial begin
        logic [31:0] cdat, hdat, exp_wd;
        logic        rd_done [2], wr_done [2];
        int          idx;

        for (int i = 0; i < (1 << AW); i++) sram[i] = 32'h0;

        // Reset values, with requests asserted during reset
        rstb = 1'b0;
        clear_inputs();
        core_wr(32'h10, 32'h1, 4'hF);
        host_if.rd_req = 1'b1;
        @(negedge clk);
        check("rst c_wr_ready", core_if.wr_ready, 0);
        check("rst h_rd_ready", host_if.rd_ready, 0);
        check("rst m_en", m_en, 0);
        check("rst m_we", m_we, 0);
        check("rst m_be", m_be, 0);
        check("rst m_addr", m_addr, 0);
        check("rst m_wdata", m_wdata, 0);
        check("rst c_rd_data", core_if.rd_data, 0);
        check("rst h_rd_data", host_if.rd_data, 0);
        check("rst addr_err", addr_err, 0);
        check("rst last_grant", last_grant, 0);
        do_reset();

        // Table: writes only, starting from reset (prio = core)
        vecs[0] = '{1'b1, 1'b0, 32'h10,   32'h0,    1'b0, 1'b1, 1'b0, 1'b1, 12'd4, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'h14,   32'h18,   1'b0, 1'b0, 1'b1, 1'b1, 12'd6, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'h14,   32'h1C,   1'b0, 1'b1, 1'b0, 1'b1, 12'd5, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 32'h0,    32'h1C,   1'b0, 1'b0, 1'b1, 1'b1, 12'd7, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 32'h0,    32'h4000, 1'b0, 1'b0, 1'b1, 1'b0, 12'd0, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 32'h8,    32'h0,    1'b0, 1'b1, 1'b0, 1'b1, 12'd2, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 32'h0,    32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 32'h0,    32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            cdat = 32'hC000_0000 | 32'(i);
            hdat = 32'hB000_0000 | 32'(i);
            core_if.wr_req = vecs[i].c_wr; core_if.addr = vecs[i].c_addr;
            core_if.wr_data = cdat; core_if.wr_be = 4'hF;
            host_if.wr_req = vecs[i].h_wr; host_if.addr = vecs[i].h_addr;
            host_if.wr_data = hdat; host_if.wr_be = 4'hF;
            err_clr = vecs[i].clr;
            exp_wd = !vecs[i].e_en ? 32'h0 : (vecs[i].e_c_rdy ? cdat : hdat);
            @(negedge clk);
            check($sformatf("vec%0d c_wr_ready", i), core_if.wr_ready, vecs[i].e_c_rdy);
            check($sformatf("vec%0d h_wr_ready", i), host_if.wr_ready, vecs[i].e_h_rdy);
            check($sformatf("vec%0d m_en", i), m_en, vecs[i].e_en);
            check($sformatf("vec%0d m_we", i), m_we, vecs[i].e_en);
            check($sformatf("vec%0d m_addr", i), m_addr, vecs[i].e_maddr);
            check($sformatf("vec%0d m_wdata", i), m_wdata, exp_wd);
            check($sformatf("vec%0d addr_err", i), addr_err, vecs[i].e_err);
            check($sformatf("vec%0d last_grant", i), last_grant, vecs[i].e_lg);
            tick();
        end
        clear_inputs();

        // Core write then read
        do_reset();
        core_wr(32'h10, 32'hDEADBEEF, 4'hF);
        @(negedge clk);
        check("wr c_wr_ready", core_if.wr_ready, 1);
        check("wr m_addr", m_addr, 4);
        check("wr m_wdata", m_wdata, 32'hDEADBEEF);
        tick();
        core_if.wr_req = 0; core_if.rd_req = 1;
        @(negedge clk);
        check("rd grant m_en", m_en, 1);
        check("rd grant m_we", m_we, 0);
        check("rd grant c_rd_ready early", core_if.rd_ready, 0);
        tick();
        @(negedge clk);
        check("rd c_rd_ready", core_if.rd_ready, 1);
        check("rd c_rd_data", core_if.rd_data, 32'hDEADBEEF);
        tick();
        core_if.rd_req = 0;
        @(negedge clk);
        check("rd after c_rd_ready", core_if.rd_ready, 0);
        check("rd after c_rd_data", core_if.rd_data, 0);
        tick();

        // Byte-enable masking
        core_wr(32'h20, 32'h11223344, 4'hF);
        tick();
        core_wr(32'h20, 32'h0000AB00, 4'h2);
        @(negedge clk);
        check("be m_be", m_be, 4'h2);
        tick();
        core_if.wr_req = 0; core_if.rd_req = 1;
        tick();
        @(negedge clk);
        check("be c_rd_data", core_if.rd_data, 32'h1122AB44);
        tick();
        core_if.rd_req = 0;

        // Continuous write contention alternates starting with core
        do_reset();
        core_wr(32'h100, 32'h1, 4'hF);
        host_if.addr = 32'h104; host_if.wr_data = 32'h2; host_if.wr_be = 4'hF; host_if.wr_req = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("cont%0d c_wr_ready", i), core_if.wr_ready, (i % 2) == 0);
            check($sformatf("cont%0d h_wr_ready", i), host_if.wr_ready, (i % 2) == 1);
            check($sformatf("cont%0d last_grant", i), last_grant, (i == 0) ? 1'b0 : 1'((i - 1) % 2));
            tick();
        end
        clear_inputs();

        // Host read vs core write to the same word, host has priority
        do_reset();
        core_wr(32'h40, 32'h77, 4'hF);
        tick();
        core_wr(32'h40, 32'h5, 4'hF);
        host_if.addr = 32'h40; host_if.rd_req = 1;
        @(negedge clk);
        check("rvw grant m_we", m_we, 0);
        check("rvw grant m_addr", m_addr, 16);
        check("rvw grant c_wr_ready", core_if.wr_ready, 0);
        tick();
        @(negedge clk);
        check("rvw h_rd_ready", host_if.rd_ready, 1);
        check("rvw h_rd_data", host_if.rd_data, 32'h77);
        check("rvw rd cycle c_wr_ready", core_if.wr_ready, 0);
        check("rvw rd cycle m_en", m_en, 0);
        tick();
        host_if.rd_req = 0;
        @(negedge clk);
        check("rvw c_wr_ready", core_if.wr_ready, 1);
        check("rvw m_we", m_we, 1);
        tick();
        core_if.wr_req = 0; core_if.rd_req = 1; core_if.addr = 32'h40;
        tick();
        @(negedge clk);
        check("rvw readback", core_if.rd_data, 32'h5);
        tick();
        core_if.rd_req = 0;

        // Out-of-range read, error clear, write with simultaneous clear
        do_reset();
        core_if.addr = 32'h4000; core_if.rd_req = 1;
        @(negedge clk);
        check("oor rd m_en", m_en, 0);
        check("oor rd addr_err pre", addr_err, 0);
        tick();
        @(negedge clk);
        check("oor c_rd_ready", core_if.rd_ready, 1);
        check("oor c_rd_data", core_if.rd_data, 0);
        check("oor addr_err set", addr_err, 1);
        tick();
        core_if.rd_req = 0; err_clr = 1;
        @(negedge clk);
        check("oor clr cycle addr_err", addr_err, 1);
        tick();
        err_clr = 0;
        @(negedge clk);
        check("oor cleared addr_err", addr_err, 0);
        tick();
        core_wr(32'h8000_0000, 32'h9, 4'hF);
        err_clr = 1;
        @(negedge clk);
        check("oor wr c_wr_ready", core_if.wr_ready, 1);
        check("oor wr m_en", m_en, 0);
        tick();
        core_if.wr_req = 0; err_clr = 0;
        @(negedge clk);
        check("oor set beats clr", addr_err, 1);
        tick();

        // Reset in the cycle after a read grant
        do_reset();
        core_wr(32'h10, 32'hDEADBEEF, 4'hF);
        tick();
        core_if.wr_req = 0; core_if.rd_req = 1;
        @(negedge clk);
        check("rmr grant m_en", m_en, 1);
        tick();
        rstb = 0;
        host_if.addr = 32'h30; host_if.wr_data = 32'h1234; host_if.wr_be = 4'hF; host_if.wr_req = 1;
        @(negedge clk);
        check("rmr c_rd_ready", core_if.rd_ready, 0);
        check("rmr c_rd_data", core_if.rd_data, 0);
        check("rmr h_wr_ready", host_if.wr_ready, 0);
        check("rmr m_en", m_en, 0);
        check("rmr last_grant", last_grant, 0);
        tick();
        rstb = 1;
        @(negedge clk);
        check("rmr post m_en", m_en, 1);
        check("rmr post m_we", m_we, 0);
        check("rmr post h_wr_ready", host_if.wr_ready, 0);
        tick();
        @(negedge clk);
        check("rmr post c_rd_ready", core_if.rd_ready, 1);
        check("rmr post c_rd_data", core_if.rd_data, 32'hDEADBEEF);
        tick();
        core_if.rd_req = 0;
        @(negedge clk);
        check("rmr post h_wr_ready late", host_if.wr_ready, 1);
        tick();
        clear_inputs();

        // Randomized traffic: core owns words 256..263, host owns 264..271
        do_reset();
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        for (int p = 0; p < 2; p++) begin
            p_rd[p] = 0; p_wr[p] = 0; p_addr[p] = 0; p_wdata[p] = 0; p_be[p] = 0; p_age[p] = 0;
        end
        oor_seen = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                wr_done[p] = 0;
                rd_done[p] = 0;
                if (wrdy[p]) begin
                    if (!p_wr[p]) begin
                        n_checks++; n_fail++;
                        $display("FAIL rand port%0d spurious wr_ready at cycle %0d", p, cyc);
                    end else begin
                        wr_done[p] = 1;
                        if (in_range(p_addr[p])) begin
                            idx = int'(p_addr[p] >> 2) - 256;
                            for (int b = 0; b < 4; b++)
                                if (p_be[p][b]) model[idx][8*b +: 8] = p_wdata[p][8*b +: 8];
                        end else oor_seen = 1;
                    end
                end
                if (rrdy[p]) begin
                    if (!p_rd[p] || p_wr[p]) begin
                        n_checks++; n_fail++;
                        $display("FAIL rand port%0d unexpected rd_ready at cycle %0d", p, cyc);
                    end else begin
                        rd_done[p] = 1;
                        if (in_range(p_addr[p])) begin
                            idx = int'(p_addr[p] >> 2) - 256;
                            check($sformatf("rand port%0d rd_data addr %h", p, p_addr[p]), rdat[p], model[idx]);
                        end else begin
                            oor_seen = 1;
                            check($sformatf("rand port%0d oor rd_data", p), rdat[p], 0);
                        end
                    end
                end else begin
                    check($sformatf("rand port%0d idle rd_data", p), rdat[p], 0);
                end
                if ((p_rd[p] || p_wr[p]) && !rd_done[p] && !wr_done[p]) begin
                    p_age[p]++;
                    if (p_age[p] > 8) begin
                        n_checks++; n_fail++;
                        $display("FAIL rand port%0d timeout at cycle %0d", p, cyc);
                        p_rd[p] = 0; p_wr[p] = 0; p_age[p] = 0;
                    end
                end
            end
            tick();
            for (int p = 0; p < 2; p++) begin
                if (wr_done[p]) begin p_wr[p] = 0; p_age[p] = 0; end
                if (rd_done[p]) begin p_rd[p] = 0; p_age[p] = 0; end
                if (!p_rd[p] && !p_wr[p] && cyc < 2900 && $urandom_range(0, 1) == 1) begin
                    int op;
                    logic [31:0] word;
                    op   = int'($urandom_range(1, 3));
                    word = 32'(256 + 8 * p) + 32'($urandom_range(0, 7));
                    p_addr[p] = (word << 2) | 32'($urandom_range(0, 3));
                    if ($urandom_range(0, 7) == 0)
                        p_addr[p] = p_addr[p] | (32'($urandom_range(1, 255)) << 14);
                    p_wdata[p] = $urandom;
                    p_be[p]    = 4'($urandom_range(0, 15));
                    p_wr[p]    = (op == 1) || (op == 3);
                    p_rd[p]    = (op == 2) || (op == 3);
                end
            end
            drive_ports();
        end
        @(negedge clk);
        check("rand drained core", {30'h0, p_rd[0], p_wr[0]}, 0);
        check("rand drained host", {30'h0, p_rd[1], p_wr[1]}, 0);
        check("rand addr_err", addr_err, oor_seen);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
